cacheline_adaptor: RTL and testbench

Memory-side responder for the cache's physical-memory port. Accepts one 256-bit line read or write request from the cache datapath/control (pmem_address, pmem_rdata, pmem_wdata, pmem_read, pmem_write, pmem_resp). Converts each request into a 4-beat 64-bit burst transaction on the DRAM bus. Returns a single-cycle completion response to the cache. Sits between the cache and the burst memory model.

---
 rtl/cacheline_adaptor.sv | 142 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges the cache's 256-bit physical-memory port onto a 4-beat x 64-bit DRAM burst bus.
// One line request becomes one burst; completion is reported with a single-cycle pmem_resp pulse.
module cacheline_adaptor #(
  parameter int S_LINE  = 256,
  parameter int S_BURST = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        i_pmem_address,
  input  logic               i_pmem_read,
  input  logic               i_pmem_write,
  input  logic [S_LINE-1:0]  i_pmem_wdata,
  output logic [S_LINE-1:0]  o_pmem_rdata,
  output logic               o_pmem_resp,
  output logic [31:0]        o_burst_address,
  output logic               o_burst_read,
  output logic               o_burst_write,
  output logic [S_BURST-1:0] o_burst_wdata,
  input  logic [S_BURST-1:0] i_burst_rdata,
  input  logic               i_burst_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_cnt;
  logic [S_LINE-1:0]  r_line;
  logic [31:0]        r_addr;
  logic               w_beat;
  logic               w_last;
  logic [31:0]        w_aligned_addr;
  logic [S_BURST-1:0] w_cur_slice;

  // A beat only counts while a burst is in flight; stray handshakes elsewhere are dropped.
  assign w_beat         = i_burst_resp && ((r_state == READ) || (r_state == WRITE));
  assign w_last         = w_beat && (r_cnt == 2'd3);
  assign w_aligned_addr = {i_pmem_address[31:5], 5'b0};
  assign w_cur_slice    = r_line[int'(r_cnt)*S_BURST +: S_BURST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_pmem_read) begin
          w_next_state = READ;
        end else if (i_pmem_write) begin
          w_next_state = WRITE;
        end
      end
      READ: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      WRITE: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Address, beat counter and line buffer; the buffer doubles as read assembly and write source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_line <= '0;
      r_addr <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_pmem_read) begin
            r_addr <= w_aligned_addr;
            r_cnt  <= 2'd0;
          end else if (i_pmem_write) begin
            r_addr <= w_aligned_addr;
            r_line <= i_pmem_wdata;
            r_cnt  <= 2'd0;
          end
        end
        READ: begin
          if (w_beat) begin
            r_line[int'(r_cnt)*S_BURST +: S_BURST] <= i_burst_rdata;
            r_cnt <= r_cnt + 2'd1;
          end
        end
        WRITE: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    o_pmem_resp   = 1'b0;
    o_burst_read  = 1'b0;
    o_burst_write = 1'b0;
    o_burst_wdata = '0;
    case (r_state)
      READ: begin
        o_burst_read = 1'b1;
      end
      WRITE: begin
        o_burst_write = 1'b1;
        o_burst_wdata = w_cur_slice;
      end
      DONE: begin
        o_pmem_resp = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_pmem_rdata    = r_line;
  assign o_burst_address = r_addr;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: inputs driven and outputs checked on the falling edge.
// Expected lines, beats and addresses are hand-computed constants.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  pmemAddress = 32'd0;
  logic         pmemRead = 1'b0;
  logic         pmemWrite = 1'b0;
  logic [255:0] pmemWdata = '0;
  logic [255:0] pmemRdata;
  logic         pmemResp;
  logic [31:0]  burstAddress;
  logic         burstRead;
  logic         burstWrite;
  logic [63:0]  burstWdata;
  logic [63:0]  burstRdata = 64'd0;
  logic         burstResp = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D3 = 64'h0F1E_2D3C_4B5A_6978;

  cacheline_adaptor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_pmem_address  (pmemAddress),
    .i_pmem_read     (pmemRead),
    .i_pmem_write    (pmemWrite),
    .i_pmem_wdata    (pmemWdata),
    .o_pmem_rdata    (pmemRdata),
    .o_pmem_resp     (pmemResp),
    .o_burst_address (burstAddress),
    .o_burst_read    (burstRead),
    .o_burst_write   (burstWrite),
    .o_burst_wdata   (burstWdata),
    .i_burst_rdata   (burstRdata),
    .i_burst_resp    (burstResp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a request for one cycle; returns at the falling edge of the first burst cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] wdata);
    @(negedge clk);
    pmemRead    = rd;
    pmemWrite   = wr;
    pmemAddress = addr;
    pmemWdata   = wdata;
    @(negedge clk);
    pmemRead  = 1'b0;
    pmemWrite = 1'b0;
  endtask

  // Bit c of respMask raises burst_resp in burst cycle c (cycle 1 is the first burst cycle).
  task automatic runRead(input string tag, input logic [31:0] expAddr, input logic [15:0] respMask,
                         input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0] beats [4];
    int beat;
    beats = '{b0, b1, b2, b3};
    beat = 0;
    for (int cyc = 1; cyc < 16 && beat < 4; cyc++) begin
      checkOutput({tag, " burst_read"}, 256'(burstRead), 256'(1'b1));
      checkOutput({tag, " burst_write"}, 256'(burstWrite), 256'(1'b0));
      checkOutput({tag, " burst_address"}, 256'(burstAddress), 256'(expAddr));
      checkOutput({tag, " early pmem_resp"}, 256'(pmemResp), 256'(1'b0));
      pmemAddress = $urandom;
      if (respMask[cyc]) begin
        burstResp  = 1'b1;
        burstRdata = beats[beat];
        beat++;
      end else begin
        burstResp  = 1'b0;
        burstRdata = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    burstResp = 1'b0;
    checkOutput({tag, " pmem_resp"}, 256'(pmemResp), 256'(1'b1));
    checkOutput({tag, " burst_read drop"}, 256'(burstRead), 256'(1'b0));
    checkOutput({tag, " pmem_rdata"}, pmemRdata, {b3, b2, b1, b0});
    @(negedge clk);
    checkOutput({tag, " pmem_resp single"}, 256'(pmemResp), 256'(1'b0));
  endtask

  task automatic runWrite(input string tag, input logic [31:0] expAddr, input logic [15:0] respMask,
                          input logic [255:0] line);
    int beat;
    beat = 0;
    for (int cyc = 1; cyc < 16 && beat < 4; cyc++) begin
      checkOutput({tag, " burst_write"}, 256'(burstWrite), 256'(1'b1));
      checkOutput({tag, " burst_read"}, 256'(burstRead), 256'(1'b0));
      checkOutput({tag, " burst_wdata"}, 256'(burstWdata), 256'(line[64*beat +: 64]));
      checkOutput({tag, " burst_address"}, 256'(burstAddress), 256'(expAddr));
      checkOutput({tag, " early pmem_resp"}, 256'(pmemResp), 256'(1'b0));
      if (respMask[cyc]) begin
        burstResp = 1'b1;
        beat++;
      end else begin
        burstResp = 1'b0;
      end
      @(negedge clk);
    end
    burstResp = 1'b0;
    checkOutput({tag, " pmem_resp"}, 256'(pmemResp), 256'(1'b1));
    checkOutput({tag, " burst_write drop"}, 256'(burstWrite), 256'(1'b0));
    @(negedge clk);
    checkOutput({tag, " pmem_resp single"}, 256'(pmemResp), 256'(1'b0));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset pmem_resp", 256'(pmemResp), 256'(1'b0));
    checkOutput("reset pmem_rdata", pmemRdata, 256'd0);
    checkOutput("reset burst_read", 256'(burstRead), 256'(1'b0));
    checkOutput("reset burst_write", 256'(burstWrite), 256'(1'b0));
    checkOutput("reset burst_address", 256'(burstAddress), 256'd0);
    checkOutput("reset burst_wdata", 256'(burstWdata), 256'd0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0);
    runRead("read b2b", 32'h0000_1220, 16'h001E,
            64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);

    // Handshakes while idle must neither start a burst nor disturb the held line.
    for (int i = 0; i < 3; i++) begin
      burstResp  = 1'b1;
      burstRdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      checkOutput("idle resp burst_read", 256'(burstRead), 256'(1'b0));
      checkOutput("idle resp burst_write", 256'(burstWrite), 256'(1'b0));
      checkOutput("idle resp pmem_resp", 256'(pmemResp), 256'(1'b0));
      checkOutput("idle resp pmem_rdata", pmemRdata,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    end
    burstResp = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'h0040_00FF, '0);
    runRead("read gaps", 32'h0040_00E0, 16'h0264,
            64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);

    applyStimulus(1'b0, 1'b1, 32'h2000_001F, {D3, D2, D1, D0});
    runWrite("write", 32'h2000_0000, 16'h00AA, {D3, D2, D1, D0});

    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0000_0C40, '0);
    runRead("read after write", 32'h0000_0C40, 16'h001E,
            64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);

    applyStimulus(1'b1, 1'b1, 32'hABCD_EF7F, {4{64'hFFFF_0000_FFFF_0000}});
    runRead("read+write", 32'hABCD_EF60, 16'h001E,
            64'h9999_9999_9999_9999, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC);

    // Abort a write while beat 2 is on the bus.
    applyStimulus(1'b0, 1'b1, 32'h0000_8040, {D3, D2, D1, D0});
    burstResp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    burstResp = 1'b0;
    checkOutput("pre-reset burst_wdata", 256'(burstWdata), 256'(D2));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset burst_write", 256'(burstWrite), 256'(1'b0));
    checkOutput("async reset burst_wdata", 256'(burstWdata), 256'd0);
    checkOutput("async reset burst_address", 256'(burstAddress), 256'd0);
    checkOutput("async reset pmem_resp", 256'(pmemResp), 256'(1'b0));
    checkOutput("async reset pmem_rdata", pmemRdata, 256'd0);
    checkOutput("async reset burst_read", 256'(burstRead), 256'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    burstResp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post-reset pmem_resp", 256'(pmemResp), 256'(1'b0));
      checkOutput("post-reset burst_write", 256'(burstWrite), 256'(1'b0));
      checkOutput("post-reset burst_read", 256'(burstRead), 256'(1'b0));
    end
    burstResp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
